wb_bus_timeout: RTL and testbench

- Wishbone bus watchdog placed directly downstream of the master-side bus mux, between its slave-side output and the target slave or decoder.
- Passes every cycle through combinationally.
- Counts wait cycles per beat; if the slave never terminates a beat, the block aborts it toward the slave and returns a single-cycle err to the master, so a dead slave cannot hang the bus or the arbiter.
- Records the failing address and a saturating event count for debug.

---
 rtl/wb_bus_timeout.sv | 166 ++++++++++++++++
 tb/tb_wb_bus_timeout.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_timeout.sv
// wb_bus_timeout
//   Wishbone bus watchdog that sits between the master-side bus mux and the
//   target slave/decoder. In normal operation every signal passes straight
//   through with no added latency. If a beat stays unterminated for TIMEOUT
//   cycles, the block spends one cycle in ABORT. In that cycle it drops
//   cyc/stb toward the slave and returns a single-cycle err to the master.
//   A dead slave therefore cannot hang the bus or the arbiter.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   m_*_i / m_*_o        master-side (mux) request inputs and response outputs
//   s_*_o / s_*_i        slave-side request outputs and response inputs
//   timeout_o            one-cycle pulse during the abort cycle
//   timeout_adr_o        address of the most recent timed-out beat
//   timeout_cnt_o        saturating count of timeouts
//   clr_i                clears timeout_cnt_o (wins over a same-cycle increment)
//
// TIMEOUT = 0 disables the watchdog, so the block is a pure pass-through.
// CNT_WIDTH must satisfy 2**CNT_WIDTH > TIMEOUT.
module wb_bus_timeout #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8,
    localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // master side (from / to the bus mux)
    input  logic [ADDR_WIDTH-1:0] m_adr_i,
    input  logic [DATA_WIDTH-1:0] m_dat_i,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    input  logic [SEL_WIDTH-1:0]  m_sel_i,
    input  logic                  m_we_i,
    input  logic [2:0]            m_cti_i,
    input  logic [1:0]            m_bte_i,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic                  m_rty_o,
    // slave side
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    output logic                  s_we_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    // debug
    output logic                  timeout_o,
    output logic [ADDR_WIDTH-1:0] timeout_adr_o,
    output logic [7:0]            timeout_cnt_o,
    input  logic                  clr_i
);

    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        RUN   = 1'b0,
        ABORT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_WIDTH-1:0]  wait_cnt_q;
    logic                  waiting;
    logic                  abort_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign waiting = m_cyc_i & m_stb_i & ~(s_ack_i | s_err_i | s_rty_i);

    // A termination arriving on the last allowed cycle clears 'waiting',
    // so the slave wins the race against the watchdog.
    assign abort_hit = WD_EN && (state_q == RUN) && waiting && (wait_cnt_q == TO_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ABORT lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (abort_hit) state_d = ABORT;
            ABORT:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Per-beat wait counter. Any break in 'waiting' restarts the budget,
    // so every burst beat gets a fresh TIMEOUT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (!WD_EN || (state_q == ABORT) || !waiting) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Debug capture: failing address and saturating event count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timeout_adr_o <= '0;
            timeout_cnt_o <= '0;
        end else begin
            if (abort_hit) begin
                timeout_adr_o <= m_adr_i;
            end
            if (clr_i) begin
                timeout_cnt_o <= '0;
            end else if (abort_hit) begin
                timeout_cnt_o <= sat_inc(timeout_cnt_o);
            end
        end
    end

    // Output logic: pass-through, overridden while in reset or in ABORT
    always_comb begin
        s_adr_o   = m_adr_i;
        s_dat_o   = m_dat_i;
        s_sel_o   = m_sel_i;
        s_we_o    = m_we_i;
        s_cti_o   = m_cti_i;
        s_bte_o   = m_bte_i;
        s_cyc_o   = m_cyc_i;
        s_stb_o   = m_stb_i;
        m_dat_o   = s_dat_i;
        m_ack_o   = s_ack_i;
        m_err_o   = s_err_i;
        m_rty_o   = s_rty_i;
        timeout_o = 1'b0;
        if (!rst_ni) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
            m_ack_o = 1'b0;
            m_err_o = 1'b0;
            m_rty_o = 1'b0;
        end else if (state_q == ABORT) begin
            s_cyc_o   = 1'b0;
            s_stb_o   = 1'b0;
            m_ack_o   = 1'b0;
            m_rty_o   = 1'b0;
            m_err_o   = 1'b1;
            timeout_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_bus_timeout.sv
module tb_wb_bus_timeout;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_dat = '0;
    logic        m_cyc = 1'b0;
    logic        m_stb = 1'b0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0;
    logic [2:0]  m_cti = '0;
    logic [1:0]  m_bte = '0;
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic        s_rty = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] o_mdat, o_sadr, o_sdat, o_tadr;
    logic        o_mack, o_merr, o_mrty, o_scyc, o_sstb, o_swe, o_tmo;
    logic [3:0]  o_ssel;
    logic [2:0]  o_scti;
    logic [1:0]  o_sbte;
    logic [7:0]  o_tcnt;

    logic [31:0] z_mdat, z_sadr, z_sdat, z_tadr;
    logic        z_mack, z_merr, z_mrty, z_scyc, z_sstb, z_swe, z_tmo;
    logic [3:0]  z_ssel;
    logic [2:0]  z_scti;
    logic [1:0]  z_sbte;
    logic [7:0]  z_tcnt;

    wb_bus_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO), .CNT_WIDTH(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_sel_i(m_sel), .m_we_i(m_we), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(o_mdat), .m_ack_o(o_mack), .m_err_o(o_merr), .m_rty_o(o_mrty),
        .s_adr_o(o_sadr), .s_dat_o(o_sdat), .s_cyc_o(o_scyc), .s_stb_o(o_sstb),
        .s_sel_o(o_ssel), .s_we_o(o_swe), .s_cti_o(o_scti), .s_bte_o(o_sbte),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .timeout_o(o_tmo), .timeout_adr_o(o_tadr), .timeout_cnt_o(o_tcnt), .clr_i(clr)
    );

    // Watchdog disabled: must behave as a plain pass-through
    wb_bus_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0), .CNT_WIDTH(8)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_sel_i(m_sel), .m_we_i(m_we), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(z_mdat), .m_ack_o(z_mack), .m_err_o(z_merr), .m_rty_o(z_mrty),
        .s_adr_o(z_sadr), .s_dat_o(z_sdat), .s_cyc_o(z_scyc), .s_stb_o(z_sstb),
        .s_sel_o(z_ssel), .s_we_o(z_swe), .s_cti_o(z_scti), .s_bte_o(z_sbte),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .timeout_o(z_tmo), .timeout_adr_o(z_tadr), .timeout_cnt_o(z_tcnt), .clr_i(clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mdl_stall: number of consecutive earlier cycles the current beat has
    // been requested without any slave termination. The beat is aborted
    // when the cycle being evaluated would be its TO-th stalled cycle;
    // the following cycle is the abort cycle.
    bit          started = 1'b0;
    bit          mdl_abort = 1'b0;
    int          mdl_stall = 0;
    logic [31:0] mdl_adr = '0;
    int          mdl_cnt = 0;

    wire req  = m_cyc & m_stb;
    wire term = s_ack | s_err | s_rty;
    wire fire = rst_n && !mdl_abort && req && !term && (mdl_stall + 1 == TO);

    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            mdl_abort <= 1'b0;
            mdl_stall <= 0;
            mdl_adr   <= '0;
            mdl_cnt   <= 0;
        end else begin
            mdl_abort <= fire;
            if (mdl_abort || !req || term || fire) mdl_stall <= 0;
            else mdl_stall <= mdl_stall + 1;
            if (fire) mdl_adr <= m_adr;
            if (clr) mdl_cnt <= 0;
            else if (fire) mdl_cnt <= (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            logic pass;
            pass = rst_n && !mdl_abort;
            chk("s_cyc", 32'(o_scyc), 32'(pass ? m_cyc : 1'b0));
            chk("s_stb", 32'(o_sstb), 32'(pass ? m_stb : 1'b0));
            chk("m_ack", 32'(o_mack), 32'(pass ? s_ack : 1'b0));
            chk("m_rty", 32'(o_mrty), 32'(pass ? s_rty : 1'b0));
            chk("m_err", 32'(o_merr), 32'(!rst_n ? 1'b0 : (mdl_abort ? 1'b1 : s_err)));
            chk("timeout", 32'(o_tmo), 32'(rst_n && mdl_abort));
            chk("m_dat", o_mdat, s_dat);
            chk("s_adr", o_sadr, m_adr);
            chk("s_dat", o_sdat, m_dat);
            chk("s_sel", 32'(o_ssel), 32'(m_sel));
            chk("s_we", 32'(o_swe), 32'(m_we));
            chk("s_cti", 32'(o_scti), 32'(m_cti));
            chk("s_bte", 32'(o_sbte), 32'(m_bte));
            chk("timeout_adr", o_tadr, mdl_adr);
            chk("timeout_cnt", 32'(o_tcnt), 32'(mdl_cnt));
            // disabled watchdog instance
            chk("z_s_cyc", 32'(z_scyc), 32'(rst_n & m_cyc));
            chk("z_m_err", 32'(z_merr), 32'(rst_n & s_err));
            chk("z_m_ack", 32'(z_mack), 32'(rst_n & s_ack));
            chk("z_timeout", 32'(z_tmo), 32'(0));
            chk("z_timeout_cnt", 32'(z_tcnt), 32'(0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_bus();
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; clr = 1'b0;
        m_cti = 3'b000;
    endtask

    // Hold a beat with a silent slave until the abort cycle (cycle TO).
    task automatic stall_to_abort(input logic [31:0] adr, input bit clr_on_entry);
        m_adr = adr; m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 0; i < TO; i++) begin
            if (clr_on_entry && i == TO - 1) clr = 1'b1;
            next();
            clr = 1'b0;
        end
    endtask

    initial begin
        int acks;
        // reset
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1;
        next();
        settle();
        chk("rst s_cyc", 32'(o_scyc), 32'(0));
        chk("rst m_ack", 32'(o_mack), 32'(0));
        chk("rst timeout_cnt", 32'(o_tcnt), 32'(0));
        chk("rst timeout_adr", o_tadr, 32'h0);
        chk("rst timeout", 32'(o_tmo), 32'(0));
        idle_bus();
        next();
        rst_n = 1'b1;
        next();

        // pass-through read, ack in cycle 2
        m_adr = 32'h100; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        next();
        next();
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        settle();
        chk("pt m_ack", 32'(o_mack), 32'(1));
        chk("pt m_dat", o_mdat, 32'hDEADBEEF);
        chk("pt m_err", 32'(o_merr), 32'(0));
        next();
        idle_bus();
        settle();
        chk("pt timeout_cnt", 32'(o_tcnt), 32'(0));
        next();

        // race: ack in cycle 3, master keeps requesting in cycle 4
        m_adr = 32'h300; m_cyc = 1'b1; m_stb = 1'b1;
        next(); next(); next();
        s_ack = 1'b1;
        settle();
        chk("race m_ack", 32'(o_mack), 32'(1));
        chk("race m_err", 32'(o_merr), 32'(0));
        next();
        s_ack = 1'b0;
        settle();
        chk("race no err c4", 32'(o_merr), 32'(0));
        chk("race no timeout c4", 32'(o_tmo), 32'(0));
        chk("race s_cyc c4", 32'(o_scyc), 32'(1));
        next();
        idle_bus();
        settle();
        chk("race timeout_cnt", 32'(o_tcnt), 32'(0));
        next();

        // 4-beat incrementing burst, each beat acked after 3 wait cycles
        acks = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_bte = 2'b00;
        for (int b = 0; b < 4; b++) begin
            m_adr = 32'h400 + 32'(4 * b);
            m_cti = (b == 3) ? 3'b111 : 3'b010;
            next(); next(); next();
            s_ack = 1'b1;
            settle();
            if (o_mack === 1'b1 && o_merr === 1'b0) acks++;
            next();
            s_ack = 1'b0;
        end
        idle_bus();
        settle();
        chk("burst acks", 32'(acks), 32'(4));
        chk("burst timeout_cnt", 32'(o_tcnt), 32'(0));
        next();

        // timeout at adr 0x2000
        stall_to_abort(32'h2000, 1'b0);
        settle();
        chk("to m_err", 32'(o_merr), 32'(1));
        chk("to s_cyc", 32'(o_scyc), 32'(0));
        chk("to timeout", 32'(o_tmo), 32'(1));
        chk("to timeout_adr", o_tadr, 32'h2000);
        chk("to timeout_cnt", 32'(o_tcnt), 32'(1));
        next();
        idle_bus();
        settle();
        chk("to pulse ends", 32'(o_tmo), 32'(0));
        next();

        // late ack during the abort cycle is suppressed
        stall_to_abort(32'h2100, 1'b0);
        s_ack = 1'b1;
        settle();
        chk("late m_ack", 32'(o_mack), 32'(0));
        chk("late m_err", 32'(o_merr), 32'(1));
        chk("late timeout_cnt", 32'(o_tcnt), 32'(2));
        next();
        idle_bus();
        next();

        // clr on the same edge as a timeout increment
        stall_to_abort(32'h2200, 1'b1);
        settle();
        chk("clr wins m_err", 32'(o_merr), 32'(1));
        chk("clr wins cnt", 32'(o_tcnt), 32'(0));
        next();
        idle_bus();
        next();

        // saturation after 256 timeouts
        for (int k = 0; k < 256; k++) begin
            stall_to_abort(32'h3000 + 32'(k), 1'b0);
            next();
            idle_bus();
            next();
        end
        settle();
        chk("sat timeout_cnt", 32'(o_tcnt), 32'(255));
        chk("sat timeout_adr", o_tadr, 32'h30FF);

        // reset mid-wait at wait cycle 2
        next();
        m_adr = 32'h5000; m_cyc = 1'b1; m_stb = 1'b1;
        next(); next();
        rst_n = 1'b0;
        settle();
        chk("rstw s_cyc", 32'(o_scyc), 32'(0));
        chk("rstw m_err", 32'(o_merr), 32'(0));
        next();
        rst_n = 1'b1;
        settle();
        chk("rstw cnt cleared", 32'(o_tcnt), 32'(0));
        next(); next(); next();
        settle();
        chk("rstw no err c3", 32'(o_merr), 32'(0));
        next();
        settle();
        chk("rstw err c4", 32'(o_merr), 32'(1));
        chk("rstw timeout_cnt", 32'(o_tcnt), 32'(1));
        next();
        idle_bus();
        clr = 1'b1;
        next();
        clr = 1'b0;
        settle();
        chk("clr pulse", 32'(o_tcnt), 32'(0));
        next();

        // randomized traffic, checked every cycle by the model compare
        for (int c = 0; c < 2500; c++) begin
            int r;
            rst_n = ($urandom_range(0, 199) != 0);
            m_cyc = ($urandom_range(0, 9) != 0);
            m_stb = m_cyc ? ($urandom_range(0, 7) != 0) : 1'($urandom);
            r = int'($urandom_range(0, 19));
            s_ack = (r < 3);
            s_err = (r == 3);
            s_rty = (r == 4);
            clr   = ($urandom_range(0, 49) == 0);
            m_adr = $urandom;
            m_dat = $urandom;
            s_dat = $urandom;
            m_sel = 4'($urandom);
            m_we  = 1'($urandom);
            m_cti = 3'($urandom);
            m_bte = 2'($urandom);
            next();
        end
        rst_n = 1'b1;
        idle_bus();
        next();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
